apb4_cmd_master: RTL and testbench
==================================

// Module: apb4_cmd_master
// PURPOSE
//  Upstream APB4 requester for the team's APB4 register slaves. Converts a valid/ready
//  command stream (one read or write per command) into a compliant APB4 SETUP/ACCESS
//  transfer, waits on pready, and returns rdata/error on a valid/ready response channel.
//  Includes a wait-state watchdog so a hung slave cannot stall the command source.
// PARAMETERS
//  ADDRWIDTH  12   width of cmd_addr/paddr (byte address)
//  TIMEOUT    255  max ACCESS cycles with pready=0 before abort; 0 = watchdog disabled
//  TO_WIDTH   8    watchdog counter width; must satisfy TIMEOUT < 2**TO_WIDTH
// PORTS
//  pclk         in   1          clock
//  preset       in   1          asynchronous reset, active-high
//  cmd_valid    in   1          command request
//  cmd_ready    out  1          command accepted when cmd_valid & cmd_ready
//  cmd_write    in   1          1 = write, 0 = read
//  cmd_addr     in   ADDRWIDTH  byte address
//  cmd_wdata    in   32         write data
//  cmd_strb     in   4          write byte strobes
//  rsp_valid    out  1          response available
//  rsp_ready    in   1          response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  32         read data (0 for writes and aborted transfers)
//  rsp_err      out  1          slave pslverr or watchdog abort
//  rsp_timeout  out  1          watchdog abort
//  psel         out  1          APB4 select
//  penable      out  1          APB4 enable
//  paddr        out  ADDRWIDTH  APB4 address, bits [1:0] always 2'b00
//  pwrite       out  1          APB4 direction
//  pwdata       out  32         APB4 write data
//  pstrb        out  4          APB4 strobes, forced 4'b0000 on reads
//  prdata       in   32         APB4 read data
//  pready       in   1          APB4 ready
//  pslverr      in   1          APB4 error
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (cmd_ready rises first cycle after preset deasserts).
//  FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  IDLE: cmd_ready=1 only here. On accept, register write/addr/wdata/strb -> SETUP.
//  SETUP: psel=1, penable=0, one cycle -> ACCESS.
//  ACCESS: psel=1, penable=1. pready=1: capture prdata (reads) and pslverr -> RESP.
//   pready=0: watchdog +1; when it reaches TIMEOUT (TIMEOUT!=0) -> RESP with
//   rsp_err=1, rsp_timeout=1, rsp_rdata=0. Watchdog cleared on entry to SETUP.
//  RESP: psel=penable=0, rsp_valid=1, all rsp_* stable until rsp_ready -> IDLE.
//  paddr/pwrite/pwdata/pstrb stable from SETUP through last ACCESS cycle; hold last value
//   otherwise. pslverr/prdata ignored unless ACCESS & pready.
//  Latency: accept at T, SETUP T+1, ACCESS T+2 (zero-wait), rsp_valid T+3; with rsp_ready=1
//   next accept T+4. Max throughput 1 command / 4 cycles. No command overlap.
//  Simultaneous pready and watchdog terminal count: pready wins (normal completion).
//  Reset mid-operation: psel/penable drop asynchronously; in-flight command dropped, no
//   response generated.
// TESTING
//  1 Write 0x000, 0xA5A51234, strb 0xF, pready=1 -> psel T+1..T+2, penable T+2, rsp_valid T+3, err 0.
//  2 Read 0x004, pready low 3 cycles, prdata 0xDEADBEEF -> 4 ACCESS cycles, pstrb 0, rsp_rdata 0xDEADBEEF.
//  3 Write 0x008 with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, rsp_rdata 0.
//  4 TIMEOUT=8, pready stuck 0 -> psel drops after 8th ACCESS cycle, rsp_err=1, rsp_timeout=1.
//  5 rsp_ready low 5 cycles, cmd_valid high -> rsp held, cmd_ready 0; next accept cycle after rsp handshake.
//  6 preset during ACCESS -> psel/penable 0 immediately, no rsp_valid, cmd_ready 1 after release.

Source files
------------

// File: rtl/apb4_cmd_master.sv
// ---------------------------------------------------------------------------
// apb4_cmd_master
//   Converts a valid/ready command stream (one read or write per command) into
//   one APB4 SETUP/ACCESS transfer. It waits on pready and returns read data
//   and error status on a valid/ready response channel. A wait-state watchdog
//   ends an ACCESS phase that has stalled for too long, so a hung slave cannot
//   block the command source.
//
//   Handshake rule for both streams: a transfer happens on the rising pclk edge
//   where valid & ready are both 1. A producer keeps valid and its payload
//   stable until that edge. ready does not depend on valid.
//
// Ports
//   pclk, preset            clock; asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (cmd_ready is 1 only in IDLE)
//   cmd_write/addr/wdata/strb  command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/err/timeout   response payload, held stable while rsp_valid=1
//   psel..pstrb             APB4 requester outputs
//   prdata/pready/pslverr   APB4 completer inputs
//   dbg_state               current FSM state (0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP)
// ---------------------------------------------------------------------------
module apb4_cmd_master #(
    parameter int ADDRWIDTH = 12,
    parameter int TIMEOUT   = 255,
    parameter int TO_WIDTH  = 8
) (
    input  logic                 pclk,
    input  logic                 preset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 psel,
    output logic                 penable,
    output logic [ADDRWIDTH-1:0] paddr,
    output logic                 pwrite,
    output logic [31:0]          pwdata,
    output logic [3:0]           pstrb,
    input  logic [31:0]          prdata,
    input  logic                 pready,
    input  logic                 pslverr,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [ADDRWIDTH-1:0] ADDR_MASK = {{(ADDRWIDTH-2){1'b1}}, 2'b00};

    state_t                state_q, state_d;
    logic                  run_q;      // holds cmd_ready low until the first edge after reset
    logic                  write_q;
    logic [ADDRWIDTH-1:0]  addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            strb_q;
    logic [TO_WIDTH-1:0]   wd_q;
    logic [31:0]           rdata_q;
    logic                  err_q;
    logic                  to_q;

    logic accept;
    logic done;
    logic wd_hit;
    logic abort;

    assign accept = cmd_valid & cmd_ready;
    assign done   = (state_q == S_ACCESS) & pready;
    // The current wait cycle is the TIMEOUT-th one. pready in the same cycle wins.
    assign wd_hit = (TIMEOUT != 0) && (wd_q == TO_WIDTH'(TIMEOUT - 1));
    assign abort  = (state_q == S_ACCESS) & ~pready & wd_hit;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: if (done || abort) state_d = S_RESP;
            S_RESP:   if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Command capture. These registers drive the APB address/data outputs and
    // keep their value until the next accept.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            write_q <= cmd_write;
            addr_q  <= cmd_addr & ADDR_MASK;
            wdata_q <= cmd_wdata;
            strb_q  <= cmd_strb;
        end
    end

    // Watchdog. It is cleared when a command moves into SETUP and counts the
    // ACCESS cycles where pready is low.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wd_q <= '0;
        end else if (accept) begin
            wd_q <= '0;
        end else if (state_q == S_ACCESS && !pready) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    // Response capture. prdata and pslverr are sampled only when the transfer
    // completes. A watchdog abort returns zero data.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else if (done) begin
            rdata_q <= write_q ? 32'h0 : prdata;
            err_q   <= pslverr;
            to_q    <= 1'b0;
        end else if (abort) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE) & run_q;
    assign psel        = (state_q == S_SETUP) | (state_q == S_ACCESS);
    assign penable     = (state_q == S_ACCESS);
    assign rsp_valid   = (state_q == S_RESP);
    assign paddr       = addr_q;
    assign pwrite      = write_q;
    assign pwdata      = wdata_q;
    assign pstrb       = write_q ? strb_q : 4'b0000;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb4_cmd_master
//   Bench for apb4_cmd_master with TIMEOUT=8. A table of commands is applied
//   in a loop. The expected response for each command is queued when the
//   command is driven and is compared when the response handshake happens.
//   Hand-written sequences cover reset at start-up and reset during ACCESS.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_apb4_cmd_master;

    localparam int AW = 12;

    logic          pclk, preset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_strb;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err, rsp_timeout;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [31:0]   pwdata, prdata;
    logic [3:0]    pstrb;
    logic          pready, pslverr;
    logic [1:0]    dbg_state;

    apb4_cmd_master #(.ADDRWIDTH(AW), .TIMEOUT(8), .TO_WIDTH(8)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];   // {rdata, err, timeout}
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    strb;
        int            waits;      // ACCESS cycles with pready low before completion
        bit            stuck;      // pready never rises
        logic [31:0]   prd;
        logic          slv;
        int            stall;      // cycles rsp_ready stays low
        bit            hold;       // keep cmd_valid high until the response handshake
        int            exp_acc;
        logic [31:0]   exp_rdata;
        logic          exp_err;
        logic          exp_to;
    } vec_t;

    vec_t vecs[9];

    // ---------------- driver ----------------
    task automatic do_cmd(input vec_t v);
        int          n;
        logic [33:0] exp;
        logic [33:0] held;
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_strb  = v.strb;
        check("cmd_ready_idle", cmd_ready, 1);
        exp_q.push_back({v.exp_rdata, v.exp_err, v.exp_to});
        @(negedge pclk);
        // SETUP phase
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, v.addr & 12'hFFC);
        check("setup_pwrite", pwrite, v.wr);
        check("setup_pwdata", pwdata, v.wdata);
        check("setup_pstrb", pstrb, v.wr ? v.strb : 4'h0);
        check("setup_cmd_ready", cmd_ready, 0);
        if (!v.hold) cmd_valid = 1'b0;
        n = 0;
        @(negedge pclk);
        while (psel && penable && n < 40) begin
            n++;
            check("access_paddr", paddr, v.addr & 12'hFFC);
            check("access_pstrb", pstrb, v.wr ? v.strb : 4'h0);
            if (!v.stuck && n > v.waits) begin
                pready  = 1'b1;
                prdata  = v.prd;
                pslverr = v.slv;
            end else begin
                // The DUT must ignore these values while pready is low.
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom_range(0, 1));
            end
            @(negedge pclk);
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        check("access_cycles", n, v.exp_acc);
        check("resp_psel", psel, 0);
        check("resp_penable", penable, 0);
        check("resp_valid", rsp_valid, 1);
        held = {rsp_rdata, rsp_err, rsp_timeout};
        repeat (v.stall) begin
            @(negedge pclk);
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_rsp_stable", {rsp_rdata, rsp_err, rsp_timeout}, held);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            exp = exp_q.pop_front();
            check("rsp_payload", {rsp_rdata, rsp_err, rsp_timeout}, exp);
        end
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_cmd_ready", cmd_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_rsp", {rsp_rdata, rsp_err, rsp_timeout}, 0);
        check("rst_state", dbg_state, 0);
        preset = 1'b0;
        #1 check("rel_cmd_ready_low", cmd_ready, 0);
        @(negedge pclk);
        check("rel_cmd_ready_high", cmd_ready, 1);

        //          wr    addr     wdata         strb  wt stk prdata        slv stl hld acc exp_rdata     err to
        vecs[0] = '{1'b1, 12'h000, 32'hA5A51234, 4'hF, 0, 0, 32'h1111_2222, 0, 0, 0, 1, 32'h0,        0, 0};
        vecs[1] = '{1'b0, 12'h004, 32'h0BAD0BAD, 4'hF, 3, 0, 32'hDEADBEEF, 0, 0, 0, 4, 32'hDEADBEEF, 0, 0};
        vecs[2] = '{1'b1, 12'h008, 32'h00C0FFEE, 4'h3, 0, 0, 32'h5555AAAA, 1, 0, 0, 1, 32'h0,        1, 0};
        vecs[3] = '{1'b0, 12'h00C, 32'h0,        4'h0, 0, 1, 32'h0,        0, 0, 0, 8, 32'h0,        1, 1};
        vecs[4] = '{1'b1, 12'h010, 32'h12345678, 4'hA, 1, 0, 32'h0,        0, 5, 1, 2, 32'h0,        0, 0};
        vecs[5] = '{1'b0, 12'hFFF, 32'h0,        4'hF, 7, 0, 32'hCAFEF00D, 0, 0, 0, 8, 32'hCAFEF00D, 0, 0};
        vecs[6] = '{1'b0, 12'h7FE, 32'h0,        4'hF, 1, 0, 32'h89ABCDEF, 1, 2, 0, 2, 32'h89ABCDEF, 1, 0};
        vecs[7] = '{1'b1, 12'h123, 32'hFEDCBA98, 4'h5, 2, 0, 32'hFFFFFFFF, 0, 1, 0, 3, 32'h0,        0, 0};
        vecs[8] = '{1'b0, 12'h100, 32'h0,        4'hF, 0, 0, 32'h0000_0001, 0, 0, 0, 1, 32'h0000_0001, 0, 0};

        for (int i = 0; i < 9; i++) do_cmd(vecs[i]);

        // Reset during ACCESS: the bus drops at once and no response follows.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h020;
        @(negedge pclk);
        cmd_valid = 1'b0;
        pready    = 1'b0;
        repeat (2) @(negedge pclk);
        check("mid_access_psel", psel & penable, 1);
        #2 preset = 1'b1;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        preset = 1'b0;
        @(negedge pclk);
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_rsp_valid", rsp_valid, 0);
        check("post_rst_state", dbg_state, 0);
        do_cmd(vecs[0]);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
